pe_conv_accum: RTL and testbench
================================

Name: pe_conv_accum

Overview:
- Clocked convolution stage directly downstream of the PE data splitter. Consumes the splitter's two output streams: filter rows (row index plus 5 packed weights) and ifmap windows (25-bit spike window, conv location, size).
- Stores up to 5 filter rows and accumulates one row per cycle, summing the weights whose ifmap spike bit is 1.
- Emits a signed partial sum tagged with the conv location toward the PE output/packetizer stage.

Parameters:
FILTER_WIDTH, 8, bits per signed weight; one filter row is 5*FILTER_WIDTH bits
PSUM_WIDTH, 16, output partial-sum width; must be >= FILTER_WIDTH+5
LOC_WIDTH, 5*FILTER_WIDTH-25, conv location width (15 at defaults)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
filt_valid  input  1  filter row write request
filt_ready  output  1  filter row accepted
filt_row  input  3  row index, 1..5
filt_data  input  5*FILTER_WIDTH  weights, column 0 in MSBs
ifmap_valid  input  1  window request
ifmap_ready  output  1  window accepted
ifmap_data  input  25  spike window, row1 col0 = bit 24
ifmap_loc  input  LOC_WIDTH  conv location tag
ifmap_size  input  2  effective kernel K = size+2 (2..5)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_psum  output  PSUM_WIDTH  signed partial sum
out_loc  output  LOC_WIDTH  location tag of out_psum
err_row  output  1  one-cycle pulse on invalid filt_row write

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; row-loaded mask = 0; out_valid=0, out_psum=0, out_loc=0, err_row=0. Weight storage need not be cleared. Reset mid-operation abandons any accumulation and any pending output.
- Handshakes: a transfer occurs on a rising edge where valid && ready. Every valid must stay asserted with stable data until accepted.
- States:
  - IDLE: filt_ready=1; ifmap_ready=1 only if all 5 rows are loaded and filt_valid=0. Filter writes take priority, so a simultaneous filt_valid blocks the ifmap that cycle.
  - ACC: both readys = 0.
  - OUT: both readys = 0.
- Filter write, row r in 1..5: store filt_data into row r and set mask bit r. Rewriting a loaded row overwrites it.
- Filter write, row 0, 6 or 7: handshake completes, data is dropped, err_row=1 for the following cycle, mask unchanged.
- Ifmap accept (edge T0):
  - latch ifmap_data, ifmap_loc, K; accumulator = 0; row counter = 0; go to ACC.
- ACC, per cycle, with row index i = counter (0-based):
  - accumulator += sum over columns c < K of (sign-extended weight[i][c] if ifmap_data[24-5i-c]==1, else 0).
  - Weight[i][c] = bits [5W-1-cW -: W] of stored row i+1.
  - Columns and rows >= K are ignored.
  - When counter == K-1, go to OUT.
- OUT: out_valid=1 and out_psum/out_loc held stable until out_ready. On handshake: out_valid=0 next cycle, go to IDLE.
- Timing: out_valid rises K cycles after T0 (edge T0+K). Minimum spacing between accepted windows is K+2 cycles with out_ready tied high.
- Arithmetic: two's-complement. Accumulation is done at PSUM_WIDTH; no saturation is needed because the width rule prevents overflow.
- Filter writes are not accepted during ACC or OUT, so the weights used in a computation are stable.

Test Plan:
- Reset, then an ifmap with all 5 rows unloaded -> ifmap_ready stays 0; out_valid stays 0.
- Load all rows with weights 1,2,3,4,5 (row data 0x0102030405); ifmap 0x1FFFFFF, size=3, loc=0x1234 -> out_psum=75 and out_loc=0x1234, with out_valid asserted 5 cycles after accept.
- Same filter, size=1 (K=3), ifmap all ones -> out_psum=18; out_valid asserted 3 cycles after accept.
- Row1 weights all 0xFF (-1), other rows 0, ifmap bits 24 and 22 set, size=3 -> out_psum=-2 (0xFFFE).
- Write with filt_row=6 -> err_row pulses once, mask unchanged, ifmap_ready still 0 if rows are missing. Also, filt_valid and ifmap_valid together in IDLE -> filter is accepted first and the ifmap is accepted the next cycle.
- Hold out_ready=0 for 4 cycles -> out_valid and out_psum are stable; assert rst mid-ACC -> out_valid=0 immediately, mask cleared.

Source files
------------

// File: rtl/pe_conv_accum_if.sv
// Stream bundle between the PE splitter, the convolution stage and the packetizer.
// valid/ready: a transfer happens on a rising clk edge where valid && ready; once raised, valid and its payload hold until that edge.
interface pe_conv_accum_if #(
    parameter int FILTER_WIDTH = 8,
    parameter int PSUM_WIDTH   = 16,
    parameter int LOC_WIDTH    = 5*FILTER_WIDTH-25
);
    logic                      filt_valid;
    logic                      filt_ready;
    logic [2:0]                filt_row;
    logic [5*FILTER_WIDTH-1:0] filt_data;
    logic                      ifmap_valid;
    logic                      ifmap_ready;
    logic [24:0]               ifmap_data;
    logic [LOC_WIDTH-1:0]      ifmap_loc;
    logic [1:0]                ifmap_size;
    logic                      out_valid;
    logic                      out_ready;
    logic [PSUM_WIDTH-1:0]     out_psum;
    logic [LOC_WIDTH-1:0]      out_loc;
    logic                      err_row;

    modport master (
        output filt_valid, filt_row, filt_data,
        output ifmap_valid, ifmap_data, ifmap_loc, ifmap_size,
        output out_ready,
        input  filt_ready, ifmap_ready, out_valid, out_psum, out_loc, err_row
    );

    modport slave (
        input  filt_valid, filt_row, filt_data,
        input  ifmap_valid, ifmap_data, ifmap_loc, ifmap_size,
        input  out_ready,
        output filt_ready, ifmap_ready, out_valid, out_psum, out_loc, err_row
    );
endinterface

// File: rtl/pe_conv_accum.sv
// Convolution stage: holds 5 filter rows and accumulates one K-wide row per cycle over
// a spike window, then presents a signed partial sum tagged with its conv location.
module pe_conv_accum #(
    parameter int FILTER_WIDTH = 8,
    parameter int PSUM_WIDTH   = 16,
    parameter int LOC_WIDTH    = 5*FILTER_WIDTH-25
) (
    input  logic        clk,
    input  logic        rst,
    pe_conv_accum_if.slave bus,
    output logic [1:0]  dbg_state
);
    localparam int ROW_W = 5*FILTER_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                state;
    logic [4:0]            row_mask;
    logic [ROW_W-1:0]      weight_mem [0:4];
    logic [24:0]           win;
    logic [LOC_WIDTH-1:0]  loc_lat;
    logic [2:0]            k_lat;
    logic [2:0]            cnt;
    logic [PSUM_WIDTH-1:0] acc;
    logic [PSUM_WIDTH-1:0] row_sum;
    logic [4:0]            spk_row;
    logic [ROW_W-1:0]      cur_row;
    logic [FILTER_WIDTH-1:0] w;
    logic                  row_ok;
    logic                  filt_fire;
    logic                  ifmap_fire;

    assign row_ok          = (bus.filt_row >= 3'd1) && (bus.filt_row <= 3'd5);
    // Filter writes win over a window in the same cycle.
    assign bus.filt_ready  = (state == IDLE);
    assign bus.ifmap_ready = (state == IDLE) && (&row_mask) && !bus.filt_valid;
    assign filt_fire       = bus.filt_valid && bus.filt_ready;
    assign ifmap_fire      = bus.ifmap_valid && bus.ifmap_ready;
    assign dbg_state       = state;

    always_ff @(posedge clk) begin
        if (filt_fire && row_ok) begin
            weight_mem[bus.filt_row - 3'd1] <= bus.filt_data;
        end
    end

    // Contribution of row cnt: columns at or beyond K are masked out.
    always_comb begin
        spk_row = 5'd0;
        case (cnt)
            3'd0:    spk_row = win[24:20];
            3'd1:    spk_row = win[19:15];
            3'd2:    spk_row = win[14:10];
            3'd3:    spk_row = win[9:5];
            3'd4:    spk_row = win[4:0];
            default: spk_row = 5'd0;
        endcase
        cur_row = weight_mem[cnt];
        row_sum = '0;
        w       = '0;
        for (int c = 0; c < 5; c++) begin
            w = cur_row[ROW_W-1-c*FILTER_WIDTH -: FILTER_WIDTH];
            if (spk_row[3'(4-c)] && (3'(c) < k_lat)) begin
                row_sum = row_sum + {{(PSUM_WIDTH-FILTER_WIDTH){w[FILTER_WIDTH-1]}}, w};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            row_mask      <= 5'd0;
            win           <= '0;
            loc_lat       <= '0;
            k_lat         <= 3'd0;
            cnt           <= 3'd0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_psum  <= '0;
            bus.out_loc   <= '0;
            bus.err_row   <= 1'b0;
        end else begin
            bus.err_row <= 1'b0;
            case (state)
                IDLE: begin
                    if (filt_fire) begin
                        if (row_ok) begin
                            row_mask[bus.filt_row - 3'd1] <= 1'b1;
                        end else begin
                            bus.err_row <= 1'b1;
                        end
                    end else if (ifmap_fire) begin
                        win     <= bus.ifmap_data;
                        loc_lat <= bus.ifmap_loc;
                        k_lat   <= {1'b0, bus.ifmap_size} + 3'd2;
                        acc     <= '0;
                        cnt     <= 3'd0;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + row_sum;
                    cnt <= cnt + 3'd1;
                    if (cnt == k_lat - 3'd1) begin
                        bus.out_valid <= 1'b1;
                        bus.out_psum  <= acc + row_sum;
                        bus.out_loc   <= loc_lat;
                        state         <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_conv_accum.sv
// Randomised bench for pe_conv_accum: a window-level arithmetic model feeds an expected
// queue that one negedge process compares against every presented result.
module tb_pe_conv_accum;
    localparam int FW = 8;
    localparam int PW = 16;
    localparam int LW = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    pe_conv_accum_if #(.FILTER_WIDTH(FW), .PSUM_WIDTH(PW), .LOC_WIDTH(LW)) bus ();

    pe_conv_accum #(.FILTER_WIDTH(FW), .PSUM_WIDTH(PW), .LOC_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rdy_mode = 0;

    int m_w [1:5][0:4];
    bit m_mask [1:5];

    logic [PW-1:0] exp_q[$];
    logic [LW-1:0] loc_q[$];
    int            t_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: 0 = always high, 1 = held low, 2 = random; changes just after posedge.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic [PW-1:0] model_psum(input logic [24:0] d, input int k);
        int s;
        s = 0;
        for (int i = 0; i < k; i++)
            for (int c = 0; c < k; c++)
                if (((d >> (24 - 5*i - c)) & 25'd1) != 25'd0) s += m_w[i+1][c];
        return s[PW-1:0];
    endfunction

    function automatic bit all_loaded();
        bit a;
        a = 1'b1;
        for (int r = 1; r <= 5; r++) a = a & m_mask[r];
        return a;
    endfunction

    task automatic model_write(input logic [2:0] row, input logic [39:0] data);
        logic signed [7:0] b;
        for (int c = 0; c < 5; c++) begin
            b = 8'(data >> (32 - 8*c));
            m_w[row][c] = int'(b);
        end
        m_mask[row] = 1'b1;
    endtask

    task automatic write_filt(input logic [2:0] row, input logic [39:0] data);
        int n;
        bit bad;
        n = 0;
        bad = (row == 3'd0) || (row > 3'd5);
        @(negedge clk);
        bus.filt_valid = 1'b1;
        bus.filt_row   = row;
        bus.filt_data  = data;
        #1;
        while (!bus.filt_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.filt_ready) begin
            timeout("filt_ready_wait");
            bus.filt_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (!bad) model_write(row, data);
        @(negedge clk);
        bus.filt_valid = 1'b0;
        check("err_row_pulse", bus.err_row, bad);
        @(negedge clk);
        check("err_row_clear", bus.err_row, 1'b0);
    endtask

    task automatic push_expect(input logic [24:0] d, input logic [LW-1:0] loc, input logic [1:0] sz);
        int k;
        k = int'(sz) + 2;
        exp_q.push_back(model_psum(d, k));
        loc_q.push_back(loc);
        t_q.push_back(cyc + k);
    endtask

    task automatic send_ifmap(input logic [24:0] d, input logic [LW-1:0] loc, input logic [1:0] sz);
        int n;
        n = 0;
        @(negedge clk);
        bus.ifmap_valid = 1'b1;
        bus.ifmap_data  = d;
        bus.ifmap_loc   = loc;
        bus.ifmap_size  = sz;
        #1;
        while (!bus.ifmap_ready && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.ifmap_ready) begin
            timeout("ifmap_ready_wait");
            bus.ifmap_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        push_expect(d, loc, sz);
        @(negedge clk);
        bus.ifmap_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || bus.out_valid) timeout("result_drain");
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) timeout("out_valid_wait");
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_psum", bus.out_psum, '0);
        check("rst_out_loc", bus.out_loc, '0);
        check("rst_err_row", bus.err_row, 1'b0);
        exp_q.delete();
        loc_q.delete();
        t_q.delete();
        for (int r = 1; r <= 5; r++) m_mask[r] = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    // Compare process: every presented result is checked for value, tag, latency and hold.
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [PW-1:0] hold_psum  = '0;
    logic [LW-1:0] hold_loc   = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("out_valid_held", bus.out_valid, 1'b1);
                check("hold_psum", bus.out_psum, hold_psum);
                check("hold_loc", bus.out_loc, hold_loc);
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual psum=%0h loc=%0h required no result", bus.out_psum, bus.out_loc);
                end else begin
                    check("out_psum", bus.out_psum, exp_q.pop_front());
                    check("out_loc", bus.out_loc, loc_q.pop_front());
                    check("out_latency", cyc, t_q.pop_front());
                end
            end
            hold_psum  = bus.out_psum;
            hold_loc   = bus.out_loc;
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.filt_valid  = 1'b0;
        bus.filt_row    = 3'd0;
        bus.filt_data   = '0;
        bus.ifmap_valid = 1'b0;
        bus.ifmap_data  = '0;
        bus.ifmap_loc   = '0;
        bus.ifmap_size  = 2'd0;
        for (int r = 1; r <= 5; r++) begin
            m_mask[r] = 1'b0;
            for (int c = 0; c < 5; c++) m_w[r][c] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_out_psum", bus.out_psum, '0);
        check("reset_out_loc", bus.out_loc, '0);
        check("reset_err_row", bus.err_row, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Window with no rows loaded is never accepted.
        @(negedge clk);
        bus.ifmap_valid = 1'b1;
        bus.ifmap_data  = 25'h1FFFFFF;
        bus.ifmap_size  = 2'd3;
        repeat (4) begin
            #1;
            check("filt_ready_idle", bus.filt_ready, 1'b1);
            check("ifmap_ready_unloaded", bus.ifmap_ready, all_loaded());
            check("out_valid_unloaded", bus.out_valid, 1'b0);
            @(negedge clk);
        end
        bus.ifmap_valid = 1'b0;

        // Rows 1..4, then a bad row index, then row 5 racing a window.
        for (int r = 1; r <= 4; r++) write_filt(3'(r), 40'h0102030405);
        write_filt(3'd6, 40'hDEADBEEF55);
        @(negedge clk);
        bus.ifmap_valid = 1'b1;
        #1;
        check("ifmap_ready_row_missing", bus.ifmap_ready, 1'b0);
        @(negedge clk);
        bus.ifmap_valid = 1'b0;

        @(negedge clk);
        bus.filt_valid  = 1'b1;
        bus.filt_row    = 3'd5;
        bus.filt_data   = 40'h0102030405;
        bus.ifmap_valid = 1'b1;
        bus.ifmap_data  = 25'h1FFFFFF;
        bus.ifmap_loc   = 15'h1234;
        bus.ifmap_size  = 2'd3;
        #1;
        check("simul_filt_ready", bus.filt_ready, 1'b1);
        check("simul_ifmap_blocked", bus.ifmap_ready, 1'b0);
        @(posedge clk);
        model_write(3'd5, 40'h0102030405);
        @(negedge clk);
        bus.filt_valid = 1'b0;
        #1;
        check("simul_ifmap_next", bus.ifmap_ready, 1'b1);
        @(posedge clk);
        #1;
        push_expect(25'h1FFFFFF, 15'h1234, 2'd3);
        check("pin_psum_75", model_psum(25'h1FFFFFF, 5), 16'd75);
        @(negedge clk);
        bus.ifmap_valid = 1'b0;
        wait_idle();

        check("pin_psum_18", model_psum(25'h1FFFFFF, 3), 16'd18);
        send_ifmap(25'h1FFFFFF, 15'h0042, 2'd1);
        wait_idle();

        // Row 1 all -1, other rows zero.
        write_filt(3'd1, 40'hFFFFFFFFFF);
        for (int r = 2; r <= 5; r++) write_filt(3'(r), 40'h0);
        check("pin_psum_neg2", model_psum(25'h1400000, 5), 16'hFFFE);
        send_ifmap(25'h1400000, 15'h7ABC, 2'd3);
        wait_idle();

        // Back-pressure: result must hold while out_ready is low.
        for (int r = 1; r <= 5; r++) write_filt(3'(r), 40'h0102030405);
        rdy_mode = 1;
        send_ifmap(25'h0F0F0F0, 15'h0555, 2'd2);
        wait_out_valid();
        repeat (4) @(negedge clk);
        rdy_mode = 0;
        wait_idle();

        // Reset in the middle of accumulation, and again while a result is pending.
        send_ifmap(25'h1FFFFFF, 15'h0011, 2'd3);
        do_reset();
        @(negedge clk);
        bus.ifmap_valid = 1'b1;
        bus.ifmap_data  = 25'h1FFFFFF;
        #1;
        check("mask_cleared_by_reset", bus.ifmap_ready, all_loaded());
        repeat (6) @(negedge clk);
        bus.ifmap_valid = 1'b0;

        for (int r = 1; r <= 5; r++) write_filt(3'(r), 40'h0102030405);
        rdy_mode = 1;
        send_ifmap(25'h1FFFFFF, 15'h0022, 2'd0);
        wait_out_valid();
        do_reset();
        rdy_mode = 0;

        // Randomised traffic with random back-pressure.
        for (int r = 1; r <= 5; r++)
            write_filt(3'(r), {$urandom(), 8'($urandom())});
        rdy_mode = 2;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 3)
                write_filt(3'($urandom_range(0, 7)), {$urandom(), 8'($urandom())});
            else
                send_ifmap(25'($urandom()), 15'($urandom()), 2'($urandom_range(0, 3)));
        end
        wait_idle();
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
